// File: rtl/bank_control_pkg.sv
// ============================================================================
// Module   : bank_control_pkg
// Brief    : Shared game constants and bank FSM state encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bank_control_pkg;

    localparam logic [9:0] c_BASE_HEIGHT = 10'd30;
    localparam logic [9:0] c_SCREEN_W    = 10'd640;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DROPPING = 2'd1,
        DEPOSIT  = 2'd2,
        COOLDOWN = 2'd3
    } bank_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bank_control_if.sv
// ============================================================================
// Module   : bank_control_if
// Brief    : Player/height-manager side signals of the bank controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bank_control_if #(
    parameter int COUNT_W = 8
);
    logic               game_en;
    logic               drop_btn;
    logic [9:0]         player_x;
    logic [9:0]         current_height;
    logic               collision;
    logic               box_dropped_in;
    logic               drop_active;
    logic [9:0]         drop_offset;
    logic [COUNT_W-1:0] bank_count;

    modport master (
        output game_en, drop_btn, player_x, current_height, collision,
        input  box_dropped_in, drop_active, drop_offset, bank_count
    );

    modport slave (
        input  game_en, drop_btn, player_x, current_height, collision,
        output box_dropped_in, drop_active, drop_offset, bank_count
    );
endinterface

`default_nettype wire

// File: rtl/bank_control_tick_edge_detect.sv
// ============================================================================
// Module   : tick_edge_detect
// Brief    : Rising-edge detector sampled only on slow-tick enables.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_edge_detect (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_en,
    input  wire logic i_din,
    output logic      o_rise
);
    logic r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= 1'b0;
        end else if (i_en) begin
            r_q <= i_din;
        end
    end

    assign o_rise = i_din & ~r_q;
endmodule

`default_nettype wire

// File: rtl/bank_control.sv
// ============================================================================
// Module   : bank_control
// Brief    : Bank-zone drop FSM: animates a falling box, pulses
//            box_dropped_in and keeps the banked score.
// Macro    : BANK_COUNT_SAT_EN - bank_count saturates instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bank_control
    import bank_control_pkg::*;
#(
    parameter logic [9:0] BASE_HEIGHT    = c_BASE_HEIGHT,
    parameter logic [9:0] BANK_X_MIN     = 10'd560,
    parameter logic [9:0] BANK_X_MAX     = 10'd639,
    parameter int         DROP_TICKS     = 16,
    parameter int         COOLDOWN_TICKS = 8,
    parameter int         COUNT_W        = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    bank_control_if.slave bus
);
    localparam int              c_CNT_W     = max_int($clog2(max_int(DROP_TICKS, COOLDOWN_TICKS)), 1);
    localparam logic [9:0]      c_STEP      = 10'(BASE_HEIGHT / DROP_TICKS);
    localparam logic [c_CNT_W-1:0] c_DROP_LAST = c_CNT_W'(DROP_TICKS - 1);
    localparam logic [c_CNT_W-1:0] c_COOL_LAST = c_CNT_W'(COOLDOWN_TICKS - 1);

    bank_state_t          r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [COUNT_W-1:0]   r_bank_count, w_bank_count_nxt, w_bank_count_inc;
    logic                 r_box_dropped, r_drop_active;
    logic [9:0]           r_drop_offset, w_offset_nxt;
    logic [31:0]          w_offset_prod;
    logic                 w_press, w_in_zone, w_can_drop;

    tick_edge_detect u_btn_edge (
        .clk    (clk),
        .rst    (rst),
        .i_en   (bus.game_en),
        .i_din  (bus.drop_btn),
        .o_rise (w_press)
    );

    assign w_in_zone  = (bus.player_x >= BANK_X_MIN) && (bus.player_x <= BANK_X_MAX);
    assign w_can_drop = bus.current_height > BASE_HEIGHT;

`ifdef BANK_COUNT_SAT_EN
    assign w_bank_count_inc = (&r_bank_count) ? r_bank_count : r_bank_count + COUNT_W'(1);
`else
    assign w_bank_count_inc = r_bank_count + COUNT_W'(1);
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_bank_count_nxt = r_bank_count;
        case (r_state)
            IDLE: begin
                if (w_press && w_in_zone && w_can_drop) begin
                    w_state_nxt = DROPPING;
                    w_cnt_nxt   = '0;
                end
            end
            DROPPING: begin
                // Losing the stack aborts the drop; leaving the zone does not.
                if (!w_can_drop) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_DROP_LAST) begin
                    w_state_nxt = DEPOSIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            DEPOSIT: begin
                if (!bus.collision) begin
                    w_state_nxt      = COOLDOWN;
                    w_cnt_nxt        = '0;
                    w_bank_count_nxt = w_bank_count_inc;
                end
            end
            COOLDOWN: begin
                if (r_cnt == c_COOL_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Offset is registered from the next counter so it tracks the counter in DROPPING.
    assign w_offset_prod = 32'(w_cnt_nxt) * 32'(c_STEP);
    assign w_offset_nxt  = (w_state_nxt != DROPPING)           ? 10'd0 :
                           (w_offset_prod > 32'(BASE_HEIGHT))  ? BASE_HEIGHT :
                                                                 10'(w_offset_prod);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_bank_count  <= '0;
            r_box_dropped <= 1'b0;
            r_drop_active <= 1'b0;
            r_drop_offset <= 10'd0;
        end else if (bus.game_en) begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_bank_count  <= w_bank_count_nxt;
            r_box_dropped <= (w_state_nxt == DEPOSIT);
            r_drop_active <= (w_state_nxt == DROPPING);
            r_drop_offset <= w_offset_nxt;
        end
    end

    assign bus.box_dropped_in = r_box_dropped;
    assign bus.drop_active    = r_drop_active;
    assign bus.drop_offset    = r_drop_offset;
    assign bus.bank_count     = r_bank_count;
endmodule

`default_nettype wire

// File: tb/tb_bank_control.sv
// ============================================================================
// Module   : tb_bank_control
// Brief    : Vector-table bench for bank_control with a narrow score counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bank_control;
    localparam int         CW    = 2;
    localparam logic [9:0] XIN   = 10'd600;
    localparam logic [9:0] XOUT  = 10'd100;
    localparam logic [9:0] HOK   = 10'd60;
    localparam logic [9:0] HLOW  = 10'd30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    bank_control_if #(.COUNT_W(CW)) bif ();

    bank_control #(.COUNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    typedef struct {
        string          name;
        logic           btn;
        logic [9:0]     x;
        logic [9:0]     h;
        logic           coll;
        logic           drop;
        logic           act;
        logic [9:0]     off;
        logic [CW-1:0]  cnt;
    } vec_t;

    typedef struct {
        string          name;
        logic           drop;
        logic           act;
        logic [9:0]     off;
        logic [CW-1:0]  cnt;
    } exp_t;

    vec_t          vecs[$];
    exp_t          sb[$];
    int            applied     = 0;
    int            miscompares = 0;
    logic [CW-1:0] ecnt        = '0;

    function automatic void add(input string n, input logic b, input logic [9:0] x,
                                input logic [9:0] h, input logic c, input logic d,
                                input logic a, input logic [9:0] o, input logic [CW-1:0] k);
        vec_t v;
        v.name = n; v.btn = b; v.x = x; v.h = h; v.coll = c;
        v.drop = d; v.act = a; v.off = o; v.cnt = k;
        vecs.push_back(v);
    endfunction

    function automatic logic [CW-1:0] bump(input logic [CW-1:0] k);
`ifdef BANK_COUNT_SAT_EN
        return (&k) ? k : k + 1'b1;
`else
        return k + 1'b1;
`endif
    endfunction

    // Full accepted drop: press, 16 falling ticks, deposit (plus retries), bank.
    function automatic void build_drop(input string n, input logic hold, input int retries,
                                       input logic [9:0] x, input logic leave);
        add({n, "_press"}, 1'b1, x, HOK, 1'b0, 1'b0, 1'b1, 10'd0, ecnt);
        for (int i = 1; i < 16; i++)
            add({n, "_fall"}, hold, (leave && i >= 5) ? XOUT : x, HOK, 1'b0,
                1'b0, 1'b1, 10'(i), ecnt);
        add({n, "_deposit"}, hold, x, HOK, 1'b0, 1'b1, 1'b0, 10'd0, ecnt);
        for (int r = 0; r < retries; r++)
            add({n, "_retry"}, hold, x, HOK, 1'b1, 1'b1, 1'b0, 10'd0, ecnt);
        ecnt = bump(ecnt);
        add({n, "_bank"}, hold, x, HOK, 1'b0, 1'b0, 1'b0, 10'd0, ecnt);
    endfunction

    function automatic void build_cooldown(input string n, input logic hold);
        for (int k = 1; k <= 8; k++)
            add(n, hold, XIN, HOK, 1'b0, 1'b0, 1'b0, 10'd0, ecnt);
    endfunction

    task automatic tick();
        @(negedge clk);
        bif.game_en = 1'b1;
        @(negedge clk);
        bif.game_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic check();
        exp_t e;
        e = sb.pop_front();
        applied++;
        if (bif.box_dropped_in !== e.drop || bif.drop_active !== e.act ||
            bif.drop_offset !== e.off || bif.bank_count !== e.cnt) begin
            miscompares++;
            $display("FAIL %s: got drop=%0b act=%0b off=%0d cnt=%0d, expected drop=%0b act=%0b off=%0d cnt=%0d",
                     e.name, bif.box_dropped_in, bif.drop_active, bif.drop_offset, bif.bank_count,
                     e.drop, e.act, e.off, e.cnt);
        end
    endtask

    task automatic push_exp(input string n, input logic d, input logic a,
                            input logic [9:0] o, input logic [CW-1:0] k);
        exp_t e;
        e.name = n; e.drop = d; e.act = a; e.off = o; e.cnt = k;
        sb.push_back(e);
    endtask

    task automatic apply(input vec_t v);
        bif.drop_btn       = v.btn;
        bif.player_x       = v.x;
        bif.current_height = v.h;
        bif.collision      = v.coll;
        push_exp(v.name, v.drop, v.act, v.off, v.cnt);
        tick();
        check();
    endtask

    task automatic run_table();
        foreach (vecs[i]) apply(vecs[i]);
        vecs.delete();
    endtask

    initial begin
        bif.game_en        = 1'b0;
        bif.drop_btn       = 1'b0;
        bif.player_x       = 10'd0;
        bif.current_height = 10'd0;
        bif.collision      = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        push_exp("reset", 1'b0, 1'b0, 10'd0, '0);
        check();
        rst = 1'b1;

        for (int i = 0; i < 5; i++)
            add("idle", 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 10'd0, ecnt);

        // First drop; presses at cooldown ticks 4 and 8 must be ignored.
        build_drop("drop1", 1'b0, 0, XIN, 1'b0);
        for (int k = 1; k <= 8; k++)
            add("cool_press", (k == 4 || k == 8), XIN, HOK, 1'b0, 1'b0, 1'b0, 10'd0, ecnt);
        add("release", 1'b0, XIN, HOK, 1'b0, 1'b0, 1'b0, 10'd0, ecnt);

        add("rej_x100", 1'b1, XOUT, HOK, 1'b0, 1'b0, 1'b0, 10'd0, ecnt);
        add("release", 1'b0, XOUT, HOK, 1'b0, 1'b0, 1'b0, 10'd0, ecnt);
        add("rej_x559", 1'b1, 10'd559, HOK, 1'b0, 1'b0, 1'b0, 10'd0, ecnt);
        add("release", 1'b0, 10'd559, HOK, 1'b0, 1'b0, 1'b0, 10'd0, ecnt);
        add("rej_x640", 1'b1, 10'd640, HOK, 1'b0, 1'b0, 1'b0, 10'd0, ecnt);
        add("release", 1'b0, 10'd640, HOK, 1'b0, 1'b0, 1'b0, 10'd0, ecnt);
        add("rej_h30", 1'b1, XIN, HLOW, 1'b0, 1'b0, 1'b0, 10'd0, ecnt);
        add("release", 1'b0, XIN, HLOW, 1'b0, 1'b0, 1'b0, 10'd0, ecnt);

        // Held button with one collision retry; holding must not re-trigger.
        build_drop("held", 1'b1, 1, XIN, 1'b0);
        build_cooldown("held_cool", 1'b1);
        for (int i = 0; i < 3; i++)
            add("held_idle", 1'b1, XIN, HOK, 1'b0, 1'b0, 1'b0, 10'd0, ecnt);
        add("release", 1'b0, XIN, HOK, 1'b0, 1'b0, 1'b0, 10'd0, ecnt);

        // Height falls mid-drop: abort with no pulse or count.
        add("abort_press", 1'b1, XIN, HOK, 1'b0, 1'b0, 1'b1, 10'd0, ecnt);
        for (int i = 1; i <= 4; i++)
            add("abort_fall", 1'b0, XIN, HOK, 1'b0, 1'b0, 1'b1, 10'(i), ecnt);
        add("abort_low", 1'b0, XIN, HLOW, 1'b0, 1'b0, 1'b0, 10'd0, ecnt);
        add("abort_idle", 1'b0, XIN, HOK, 1'b0, 1'b0, 1'b0, 10'd0, ecnt);

        // Zone edges, leaving the zone mid-drop, and counter wrap/saturation.
        build_drop("drop3", 1'b0, 0, 10'd560, 1'b1);
        build_cooldown("cool3", 1'b0);
        build_drop("drop4", 1'b0, 0, 10'd639, 1'b0);
        build_cooldown("cool4", 1'b0);
        add("after4", 1'b0, XIN, HOK, 1'b0, 1'b0, 1'b0, 10'd0, ecnt);
        run_table();

        // Asynchronous reset in the middle of a drop.
        add("pre_rst_press", 1'b1, XIN, HOK, 1'b0, 1'b0, 1'b1, 10'd0, ecnt);
        for (int i = 1; i <= 3; i++)
            add("pre_rst_fall", 1'b0, XIN, HOK, 1'b0, 1'b0, 1'b1, 10'(i), ecnt);
        run_table();
        #3 rst = 1'b0;
        #1;
        push_exp("async_rst", 1'b0, 1'b0, 10'd0, '0);
        check();
        @(negedge clk);
        rst  = 1'b1;
        ecnt = '0;
        add("post_rst_press", 1'b1, XIN, HOK, 1'b0, 1'b0, 1'b1, 10'd0, ecnt);
        for (int i = 1; i <= 3; i++)
            add("post_rst_fall", 1'b0, XIN, HOK, 1'b0, 1'b0, 1'b1, 10'(i), ecnt);
        run_table();

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule

`default_nettype wire
